// File: rtl/sha_input_manager.sv
// Nonce dispatcher for the SHA256 core array: takes one job (word + inclusive nonce range)
// and issues nonces to NUM_CORES cores in lockstep batches until the range is exhausted or found.
module sha_input_manager #(
    parameter int NUM_CORES = 2,
    parameter int DATA_W    = 352
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [DATA_W-1:0]       job_data,
    input  logic [31:0]             nonce_start,
    input  logic [31:0]             nonce_end,
    output logic [DATA_W-1:0]       core_data,
    output logic [32*NUM_CORES-1:0] core_nonce,
    output logic [NUM_CORES-1:0]    core_start,
    input  logic [NUM_CORES-1:0]    core_ready,
    input  logic                    found,
    output logic                    busy,
    output logic                    exhausted,
    output logic                    aborted,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_WAIT     = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [32:0]               cur_q, cur_d;
    logic [32:0]               end_q, end_d;
    logic [DATA_W-1:0]         core_data_q, core_data_d;
    logic [32*NUM_CORES-1:0]   core_nonce_q, core_nonce_d;
    logic [NUM_CORES-1:0]      core_start_q, core_start_d;
    logic                      exhausted_q, exhausted_d;
    logic                      aborted_q, aborted_d;
    logic                      load_batch;
    logic [32:0]               next_cur;
    logic [32:0]               lane_v;

    // 33-bit arithmetic so a range ending at 0xFFFFFFFF terminates instead of wrapping.
    assign next_cur = cur_q + 33'(NUM_CORES);

    // Job handshake: a job transfers on a rising edge where job_valid && job_ready;
    // job_ready is high exactly while idle, and the offer must be held until it transfers.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        end_d        = end_q;
        core_data_d  = core_data_q;
        core_nonce_d = core_nonce_q;
        core_start_d = '0;
        exhausted_d  = 1'b0;
        aborted_d    = 1'b0;
        load_batch   = 1'b0;
        lane_v       = '0;

        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    core_data_d = job_data;
                    cur_d       = {1'b0, nonce_start};
                    end_d       = {1'b0, nonce_end};
                    if (nonce_start > nonce_end) begin
                        exhausted_d = 1'b1;
                    end else begin
                        state_d    = S_DISPATCH;
                        load_batch = 1'b1;
                    end
                end
            end
            S_DISPATCH: begin
                if (found) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (found) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (&core_ready) begin
                    if (next_cur > end_q) begin
                        state_d     = S_IDLE;
                        exhausted_d = 1'b1;
                    end else begin
                        cur_d      = next_cur;
                        state_d    = S_DISPATCH;
                        load_batch = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Start/nonce registers are loaded on entry to DISPATCH so they are visible during it.
        if (load_batch) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                lane_v = cur_d + 33'(i);
                if (lane_v <= end_d) begin
                    core_nonce_d[32*i +: 32] = lane_v[31:0];
                    core_start_d[i]          = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            end_q        <= '0;
            core_data_q  <= '0;
            core_nonce_q <= '0;
            core_start_q <= '0;
            exhausted_q  <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            end_q        <= end_d;
            core_data_q  <= core_data_d;
            core_nonce_q <= core_nonce_d;
            core_start_q <= core_start_d;
            exhausted_q  <= exhausted_d;
            aborted_q    <= aborted_d;
        end
    end

    assign job_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign core_data  = core_data_q;
    assign core_nonce = core_nonce_q;
    assign core_start = core_start_q;
    assign exhausted  = exhausted_q;
    assign aborted    = aborted_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/sha_input_manager.md
Name: sha_input_manager

Overview:
- Nonce dispatcher on the input side of the SHA256 core array; counterpart of the output manager that collects per-core {found, nonce} results.
- Accepts one mining job (a 352-bit job word plus an inclusive nonce range) over a valid/ready handshake.
- Issues nonces to NUM_CORES cores in lockstep batches: core i gets cur+i, and cur advances by NUM_CORES per batch.
- Stops when the range is exhausted, or when `found` (OR of the output manager flags) is asserted.

Parameters:
NUM_CORES, 2, number of SHA cores served in lockstep (1..16)
DATA_W, 352, job word width (256-bit midstate + 96-bit header tail)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
job_valid  in  1  job offered
job_ready  out  1  manager can accept a job (high only in IDLE)
job_data  in  DATA_W  midstate/header tail
nonce_start  in  32  first nonce, inclusive
nonce_end  in  32  last nonce, inclusive
core_data  out  DATA_W  registered job word, shared by all cores
core_nonce  out  32*NUM_CORES  nonce for core i in bits [32i+31:32i]
core_start  out  NUM_CORES  one-cycle start pulse per core; only valid lanes pulse
core_ready  in  NUM_CORES  core idle/finished; must be high for all lanes to advance
found  in  1  golden nonce reported downstream; aborts the job
busy  out  1  high when not IDLE
exhausted  out  1  one-cycle pulse: range fully issued and last batch complete
aborted  out  1  one-cycle pulse: job stopped by found

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; cur=0.
  - core_data=0, core_nonce=0, core_start=0, busy=0, exhausted=0, aborted=0.
  - job_ready=1 from the first cycle after reset is released.
  - Reset mid-job drops the job immediately; no pulses are issued.
- States: IDLE, DISPATCH, WAIT.
- IDLE:
  - job_ready=1.
  - On job_valid&&job_ready: register job_data into core_data; cur={1'b0,nonce_start} (33-bit); end={1'b0,nonce_end}.
  - If nonce_start>nonce_end: stay IDLE and pulse exhausted next cycle; no core_start is issued.
  - Otherwise go to DISPATCH.
- DISPATCH (exactly one cycle):
  - core_nonce lane i = (cur+i)[31:0].
  - core_start[i]=1 iff cur+i <= end, compared in 33 bits. Lanes beyond end get neither a pulse nor a change of core_nonce.
  - Next state is WAIT.
- WAIT:
  - core_start=0.
  - If found=1: go IDLE and pulse aborted.
  - Else if &core_ready (checked no earlier than 1 cycle after DISPATCH):
    - if cur+NUM_CORES > end (33-bit): go IDLE and pulse exhausted;
    - else cur<=cur+NUM_CORES and go DISPATCH.
- Simultaneous events:
  - found has priority over core_ready and over exhaustion.
  - found in DISPATCH: the start pulse still issues that cycle, then the next state is IDLE with aborted pulsed.
  - found in IDLE is ignored.
- Wrap-around: all arithmetic is 33-bit. nonce_end=0xFFFFFFFF terminates correctly; cur never wraps to 0.
- Latency: job accept edge -> core_start high on the next cycle. Last core_ready -> next DISPATCH is 1 cycle.
- Output timing: exhausted/aborted are registered and high for exactly one cycle, coincident with the return to IDLE (busy=0, job_ready=1).
- core_data is held stable from accept until the next accept. core_nonce holds its last value in IDLE.
- A new job can be accepted the same cycle exhausted/aborted is high.

Test Plan:
All scenarios use NUM_CORES=2.
1. Reset: assert rst during WAIT -> next cycle state IDLE, busy=0, core_start=0, no exhausted/aborted pulse.
2. Normal job: nonce_start=0, nonce_end=3, cores ready 2 cycles after each start:
   - batch 1: core_start=2'b11, core_nonce={1,0};
   - batch 2: core_start=2'b11, core_nonce={3,2};
   - then exhausted pulses once and busy=0.
3. Partial lane: start=5, end=5 -> core_start=2'b01, lane0 nonce=5; exhausted after core_ready=2'b11.
4. Found abort: start=0, end=100, found=1 during second WAIT:
   - aborted pulses once, no third core_start is issued;
   - job_ready=1 the next cycle.
5. Range top: start=0xFFFFFFFE, end=0xFFFFFFFF -> one batch with nonces {0xFFFFFFFF, 0xFFFFFFFE}, then exhausted; no wrap to 0.
6. Empty range: start=10, end=9 -> no core_start; exhausted pulses the cycle after accept.
